// File: rtl/cpu_tick_gen_pkg.sv
// Shared defaults and helpers for the cpu_tick_gen clock-enable generator.
package cpu_tick_gen_pkg;

    localparam int CHANNELS_DEF = 2;
    localparam int ACC_W_DEF    = 32;
    localparam int MULT_W_DEF   = 5;
    localparam int PEND_W_DEF   = 4;

    // Channel index width; a single-channel build still needs a 1-bit select.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Saturation value of a pending-tick counter of the given width.
    function automatic int pend_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/cpu_tick_gen_if.sv
// Step-configuration write bus: valid/ready handshake carrying channel and step value.
interface cpu_tick_gen_if #(
    parameter int CHAN_W = 1,
    parameter int ACC_W  = 32
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CHAN_W-1:0] cfg_chan;
    logic [ACC_W-1:0]  cfg_step;

    modport master (output cfg_valid, output cfg_chan, output cfg_step, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_chan, input  cfg_step, output cfg_ready);
endinterface

// File: rtl/cpu_tick_gen_nco_chan.sv
// One tick channel: NCO phase accumulator, pending-tick counter, sticky overrun and tick strobe.
module cpu_tick_gen_nco_chan
    import cpu_tick_gen_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int MULT_W = MULT_W_DEF,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ACC_W-1:0]  load_step_i,
    input  logic [MULT_W-1:0] mult_i,
    input  logic              run_i,
    input  logic              step_req_i,
    output logic              tick_o,
    output logic              overrun_o
);

    localparam int SUM_W    = ACC_W + MULT_W + 1;
    localparam int OVF_W    = MULT_W + 1;
    localparam int CNT_W    = ((PEND_W > OVF_W) ? PEND_W : OVF_W) + 2;
    localparam int PEND_MAX = pend_max(PEND_W);

    logic [ACC_W-1:0]  acc_q,  acc_d;
    logic [ACC_W-1:0]  step_q, step_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              tick_q, tick_d;
    logic              ovr_q,  ovr_d;

    logic [SUM_W-1:0]  sum_s;
    logic [OVF_W-1:0]  ovf_s;
    logic              stepadd_s;
    logic              drain_s;
    logic [CNT_W-1:0]  pend_raw_s;

    // Next-state: accumulate, count earned ticks, drain one per cycle; a config load overrides all.
    always_comb begin
        sum_s      = SUM_W'(acc_q) + (SUM_W'(step_q) * SUM_W'(mult_i));
        acc_d      = acc_q;
        ovf_s      = '0;
        step_d     = step_q;
        pend_d     = pend_q;
        ovr_d      = ovr_q;
        tick_d     = 1'b0;
        stepadd_s  = step_req_i & ~run_i;
        drain_s    = (pend_q != '0);
        pend_raw_s = '0;
        if (load_i) begin
            step_d = load_step_i;
            acc_d  = '0;
            pend_d = '0;
            ovr_d  = 1'b0;
            tick_d = 1'b0;
        end else begin
            if (run_i) begin
                acc_d = sum_s[ACC_W-1:0];
                ovf_s = sum_s[SUM_W-1:ACC_W];
            end else begin
                acc_d = acc_q;
                ovf_s = '0;
            end
            // Drain is only taken when pending is non-zero, so this never underflows.
            pend_raw_s = CNT_W'(pend_q) + CNT_W'(ovf_s) + CNT_W'(stepadd_s) - CNT_W'(drain_s);
            if (pend_raw_s > CNT_W'(PEND_MAX)) begin
                pend_d = PEND_W'(PEND_MAX);
                ovr_d  = 1'b1;
            end else begin
                pend_d = pend_raw_s[PEND_W-1:0];
                ovr_d  = ovr_q;
            end
            tick_d = drain_s;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            step_q <= '0;
            pend_q <= '0;
            tick_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            step_q <= step_d;
            pend_q <= pend_d;
            tick_q <= tick_d;
            ovr_q  <= ovr_d;
        end
    end

    assign tick_o    = tick_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/cpu_tick_gen.sv
// Multi-channel clock-enable generator: config handshake, per-channel load decode, NCO channels.
module cpu_tick_gen
    import cpu_tick_gen_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int MULT_W   = MULT_W_DEF,
    parameter int PEND_W   = PEND_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    cpu_tick_gen_if.slave       cfg,
    input  logic [MULT_W-1:0]   mult,
    input  logic [CHANNELS-1:0] run,
    input  logic [CHANNELS-1:0] step_req,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] overrun
);

    localparam int CHAN_W = chan_w(CHANNELS);

    logic                cfg_ready_q, cfg_ready_d;
    logic                cfg_fire_s;
    logic [CHANNELS-1:0] load_s;

    // Decode an accepted write to a per-channel load strobe; out-of-range channels match nothing.
    always_comb begin
        cfg_ready_d = 1'b1;
        cfg_fire_s  = cfg.cfg_valid & cfg_ready_q;
        load_s      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_fire_s && (cfg.cfg_chan == CHAN_W'(i))) begin
                load_s[i] = 1'b1;
            end else begin
                load_s[i] = 1'b0;
            end
        end
    end

    // Ready comes up on the first clock after reset release and then stays up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready_q <= 1'b0;
        end else begin
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        cpu_tick_gen_nco_chan #(
            .ACC_W  (ACC_W),
            .MULT_W (MULT_W),
            .PEND_W (PEND_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_i      (load_s[g]),
            .load_step_i (cfg.cfg_step),
            .mult_i      (mult),
            .run_i       (run[g]),
            .step_req_i  (step_req[g]),
            .tick_o      (tick[g]),
            .overrun_o   (overrun[g])
        );
    end

endmodule
